// File: rtl/top_top.sv
// Three-stage pipelined bfloat16 log2 unit with IEEE special-case handling.
// Optional subnormal operand support is enabled by defining FLOG_SUBNORM_EN.
`timescale 1ns/1ps

package flog_pkg;
    parameter int EXP_WIDTH   = 8;
    parameter int FRACT_WIDTH = 7;
    parameter int S_WIDTH     = 1;
endpackage

module top_top
    import flog_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_WIDTH-1:0]     sign,
    input  logic [EXP_WIDTH-1:0]   exponent,
    input  logic [FRACT_WIDTH-1:0] fractional,
    input  logic                   valid_i,
    output logic [S_WIDTH-1:0]     s_res_o,
    output logic [EXP_WIDTH-1:0]   e_res_o,
    output logic [FRACT_WIDTH-1:0] f_res_o,
    output logic                   valid_o
);

    localparam int STAGES = 3;
    localparam int RES_W  = S_WIDTH + EXP_WIDTH + FRACT_WIDTH;
    localparam int LUT_W  = 16;
    localparam int FIX_W  = 25;
    localparam int LUT_N  = 1 << FRACT_WIDTH;

    localparam logic [RES_W-1:0] QNAN = 16'h7FC0;
    localparam logic [RES_W-1:0] NINF = 16'hFF80;
    localparam logic [RES_W-1:0] PINF = 16'h7F80;

    typedef struct packed {
        logic                   spec;
        logic [RES_W-1:0]       spec_res;
        logic [8:0]             k;
        logic [FRACT_WIDTH-1:0] fn;
    } s1_t;

    typedef struct packed {
        logic             spec;
        logic [RES_W-1:0] spec_res;
        logic             neg;
        logic [FIX_W-1:0] mag;
    } s2_t;

    // Elaboration-time log2(1+i/128)*2^16 by repeated squaring; 32 result
    // bits are kept so the final round-to-nearest at 16 bits is exact.
    function automatic logic [LUT_W-1:0] lut_entry(input int idx);
        logic [127:0] x;
        logic [31:0]  r;
        x = 128'(128 + idx) << 41;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            x = (x * x) >> 48;
            r = {r[30:0], 1'b0};
            if (x >= (128'd2 << 48)) begin
                r[0] = 1'b1;
                x    = x >> 1;
            end
        end
        return 16'((r + 32'h8000) >> 16);
    endfunction

    logic [LUT_W-1:0] lut [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam logic [LUT_W-1:0] ENTRY = lut_entry(g);
        assign lut[g] = ENTRY;
    end

    logic [STAGES:0] vld_pipe;
    assign vld_pipe[0] = valid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // S1: classify operand, derive integer part k and the LUT index
    s1_t s1_d, s1_q;
    logic is_nan, is_zero, is_inf, is_sub;
`ifdef FLOG_SUBNORM_EN
    logic [2:0] lz;
`endif

    always_comb begin
        is_nan  = (exponent == '1) && (fractional != '0);
        is_inf  = (exponent == '1) && (fractional == '0);
        is_zero = (exponent == '0) && (fractional == '0);
        is_sub  = (exponent == '0) && (fractional != '0);
        s1_d          = '0;
        s1_d.k        = {1'b0, exponent} - 9'd127;
        s1_d.fn       = fractional;
`ifdef FLOG_SUBNORM_EN
        lz = 3'd0;
        for (int i = 0; i < FRACT_WIDTH; i++)
            if (fractional[i]) lz = 3'(FRACT_WIDTH - 1 - i);
`endif
        if (is_nan) begin
            s1_d.spec = 1'b1; s1_d.spec_res = QNAN;
        end else if ((sign != '0) && !is_zero) begin
            s1_d.spec = 1'b1; s1_d.spec_res = QNAN;
        end else if (is_zero) begin
            s1_d.spec = 1'b1; s1_d.spec_res = NINF;
        end else if (is_inf) begin
            s1_d.spec = 1'b1; s1_d.spec_res = PINF;
        end else if (is_sub) begin
`ifdef FLOG_SUBNORM_EN
            // shift out the leading one; k = -127 - lz
            s1_d.fn = fractional << (lz + 3'd1);
            s1_d.k  = 9'h181 - {6'd0, lz};
`else
            s1_d.spec = 1'b1; s1_d.spec_res = NINF;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          s1_q <= '0;
        else if (valid_i) s1_q <= s1_d;
    end

    // S2: V = k*2^16 + LUT[f] in 9.16 fixed point, split into sign/magnitude
    s2_t              s2_d, s2_q;
    logic [FIX_W-1:0] v;

    always_comb begin
        v           = {s1_q.k, 16'd0} + {9'd0, lut[s1_q.fn]};
        s2_d.spec     = s1_q.spec;
        s2_d.spec_res = s1_q.spec_res;
        s2_d.neg      = v[FIX_W-1];
        s2_d.mag      = v[FIX_W-1] ? (FIX_W'(0) - v) : v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              s2_q <= '0;
        else if (vld_pipe[1]) s2_q <= s2_d;
    end

    // S3: normalise, round to nearest even, select special result
    logic [4:0]       p;
    logic [FIX_W-1:0] mn;
    logic             guard, sticky, rup;
    logic [7:0]       rnd;
    logic [7:0]       e_norm;
    logic [RES_W-1:0] res_d, res_q;

    always_comb begin
        p = 5'd0;
        for (int i = 0; i < FIX_W; i++)
            if (s2_q.mag[i]) p = 5'(i);
        // leading one shifted out: fraction sits at the top of mn
        mn     = s2_q.mag << (5'd25 - p);
        guard  = mn[17];
        sticky = |mn[16:0];
        rup    = guard & (sticky | mn[18]);
        rnd    = {1'b0, mn[24:18]} + {7'd0, rup};
        e_norm = 8'd111 + {3'd0, p} + {7'd0, rnd[7]};
        if (s2_q.spec)           res_d = s2_q.spec_res;
        else if (s2_q.mag == '0) res_d = '0;
        else                     res_d = {s2_q.neg, e_norm, rnd[6:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              res_q <= '0;
        else if (vld_pipe[2]) res_q <= res_d;
    end

    assign s_res_o = res_q[RES_W-1 -: S_WIDTH];
    assign e_res_o = res_q[FRACT_WIDTH +: EXP_WIDTH];
    assign f_res_o = res_q[FRACT_WIDTH-1:0];
    assign valid_o = vld_pipe[STAGES];

endmodule

// File: tb/tb_top_top.sv
// Scoreboard bench for top_top: directed special/normal cases, burst timing,
// mid-flight reset, subnormal handling and a random sweep against a golden model.
`timescale 1ns/1ps

module tb_top_top;

    logic       clk, rst;
    logic [0:0] sign;
    logic [7:0] exponent;
    logic [6:0] fractional;
    logic       valid_i;
    logic [0:0] s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o;

    top_top dut (
        .clk(clk), .rst(rst), .sign(sign), .exponent(exponent),
        .fractional(fractional), .valid_i(valid_i), .s_res_o(s_res_o),
        .e_res_o(e_res_o), .f_res_o(f_res_o), .valid_o(valid_o)
    );

    typedef struct {
        string       tag;
        logic [15:0] op;
        logic [15:0] want;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   vo_cnt = 0;
    int   lut_tb[128];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] golden(input logic [15:0] x);
        int e, f, k, fn, vv, m, p, sh, mant, rem, half, ex;
        logic neg;
        e = int'(x[14:7]);
        f = int'(x[6:0]);
        if (e == 255 && f != 0) return 16'h7FC0;
        if (x[15] && !(e == 0 && f == 0)) return 16'h7FC0;
        if (e == 0 && f == 0) return 16'hFF80;
        if (e == 255) return 16'h7F80;
        if (e == 0) begin
`ifdef FLOG_SUBNORM_EN
            int fi, z;
            fi = f; z = 0;
            while (fi < 64) begin fi = fi * 2; z++; end
            fn = (fi * 2) % 128;
            k  = -127 - z;
`else
            return 16'hFF80;
`endif
        end else begin
            k  = e - 127;
            fn = f;
        end
        vv  = k * 65536 + lut_tb[fn];
        neg = (vv < 0);
        m   = neg ? -vv : vv;
        if (m == 0) return 16'h0000;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        if (p <= 7) begin
            mant = m << (7 - p);
        end else begin
            sh   = p - 7;
            mant = m >> sh;
            rem  = m - (mant << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
        end
        ex = 111 + p;
        if (mant == 256) begin mant = 128; ex++; end
        return {neg, 8'(ex), 7'(mant)};
    endfunction

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check16(tag, {s_res_o, e_res_o, f_res_o, 7'd0, valid_o}, 16'h0000);
    endtask

    task automatic send(input logic [15:0] op, input logic [15:0] want, input string tag);
        @(negedge clk);
        {sign, exponent, fractional} = op;
        valid_i = 1'b1;
        sb.push_back('{tag, op, want});
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_rst(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && valid_o) begin
            vo_cnt++;
            if (sb.size() == 0) begin
                checks++;
                assert (1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_valid: observed %h expected none",
                           {s_res_o, e_res_o, f_res_o});
                end
            end else begin
                mon_e = sb.pop_front();
                checks++;
                assert ({s_res_o, e_res_o, f_res_o} === mon_e.want) else begin
                    errors++;
                    $error("FAIL %s op=%h: observed %h expected %h", mon_e.tag,
                           mon_e.op, {s_res_o, e_res_o, f_res_o}, mon_e.want);
                end
            end
        end
    end

    logic [15:0] bop [4];
    logic [9:0]  vvec;
    logic [15:0] rop;
    int          vo_before;

    initial begin
        for (int i = 0; i < 128; i++)
            lut_tb[i] = int'($floor($ln(1.0 + i / 128.0) / $ln(2.0) * 65536.0 + 0.5));
        rst = 1'b1; valid_i = 1'b0;
        sign = '0; exponent = '0; fractional = '0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        send(16'h7F80, 16'h7F80, "pinf");    pulse_rst("rst_after_pinf");
        send(16'h0000, 16'hFF80, "pzero");   pulse_rst("rst_after_pzero");
        send(16'h8000, 16'hFF80, "nzero");   pulse_rst("rst_after_nzero");
        send(16'h7FC0, 16'h7FC0, "qnan");    pulse_rst("rst_after_qnan");
        send(16'h7FBF, 16'h7FC0, "snan");    pulse_rst("rst_after_snan");
        send(16'hD550, 16'h7FC0, "negative"); pulse_rst("rst_after_neg");

        send(16'h3F80, 16'h0000, "one");
        send(16'h4000, 16'h3F80, "two");
        send(16'h3F00, 16'hBF80, "half");
        send(16'h7DAB, 16'h42F9, "exp251");
        send(16'h47FA, 16'h4188, "exp143");

        bop[0] = 16'h47FA; bop[1] = 16'h4000; bop[2] = 16'h3F00; bop[3] = 16'h7DAB;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vvec[i] = valid_o;
            if (i < 4) begin
                {sign, exponent, fractional} = bop[i];
                valid_i = 1'b1;
                sb.push_back('{"burst", bop[i], golden(bop[i])});
            end else begin
                valid_i = 1'b0;
            end
        end
        check16("burst_valid_pattern", {6'd0, vvec}, 16'h0078);
        repeat (3) @(negedge clk);
        check16("hold_result", {s_res_o, e_res_o, f_res_o}, 16'h42F9);
        check16("hold_valid_low", {15'd0, valid_o}, 16'h0000);

        @(negedge clk);
        {sign, exponent, fractional} = 16'h4000;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("midflight_reset");
        vo_before = vo_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check16("no_valid_after_reset", 16'(vo_cnt), 16'(vo_before));

`ifdef FLOG_SUBNORM_EN
        send(16'h0001, 16'hC305, "subnormal");
`else
        send(16'h0001, 16'hFF80, "subnormal");
`endif

        for (int i = 0; i < 1000; i++) begin
            rop = {1'b0, 8'($urandom_range(0, 255)), 7'($urandom_range(0, 127))};
            send(rop, golden(rop), "random");
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check16("scoreboard_drained", 16'(sb.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
